// File: rtl/bin_compress.sv
// bin_compress: writer side of the binary-bin path.
// Reduces each COMP_WIDTH x COMP_HEIGHT block of a binary mask stream to
// a single bin bit (1 when the block's set-pixel count exceeds THRESH).
// Bins leave in raster order, two clocks after the block's closing pixel.
// A horizontal adder sums each COMP_WIDTH-pixel run. A per-column
// accumulator then folds the runs over the lines of the block band.

module bin_compress #(
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int COMP_WIDTH  = 8,
  parameter int COMP_HEIGHT = 10,
  parameter int THRESH      = COMP_WIDTH * COMP_HEIGHT / 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       vsync,
  input  logic                       de,
  input  logic                       pix,
  input  logic [$clog2(H_ACT)-1:0]   x,
  input  logic [$clog2(V_ACT)-1:0]   y,
  output logic                       bin_valid,
  output logic                       bin,
  output logic                       bin_cls,
  output logic                       bin_next
);

  localparam int XW     = $clog2(H_ACT);
  localparam int YW     = $clog2(V_ACT);
  localparam int BINS_X = H_ACT / COMP_WIDTH;
  localparam int BINS_Y = V_ACT / COMP_HEIGHT;
  localparam int CNT_W  = $clog2(COMP_WIDTH * COMP_HEIGHT + 1);
  localparam int HW     = $clog2(COMP_WIDTH + 1);
  localparam int COLW   = (BINS_X > 1) ? $clog2(BINS_X) : 1;
  localparam int LW     = (COMP_HEIGHT > 1) ? $clog2(COMP_HEIGHT) : 1;

  // Frame arming
  logic vsync_d;
  logic armed;
  logic vs_rise;

  // Input decode
  logic [XW-1:0]   x_in_blk;
  logic [COLW-1:0] col_idx;
  logic [LW-1:0]   line_idx;
  logic            in_range;
  logic            take;
  logic            blk_first;
  logic            blk_last;
  logic [HW-1:0]   partial;

  // Horizontal stage
  logic [HW-1:0]   hcnt;

  // Column stage (one partial sum in flight)
  logic            s1_valid;
  logic [HW-1:0]   s1_part;
  logic [COLW-1:0] s1_col;
  logic [LW-1:0]   s1_line;

  logic [CNT_W-1:0] colacc [BINS_X];
  logic [CNT_W-1:0] acc_rd;
  logic [CNT_W-1:0] col_sum;
  logic             s1_first;
  logic             s1_last;
  logic             emit;

  // The rising edge is detected against the registered copy of vsync.
  assign vs_rise = vsync & ~vsync_d;

  // Decode pixel position. Classify the pixel within its block. Form the running run sum.
  always_comb begin
    x_in_blk  = x % XW'(COMP_WIDTH);
    col_idx   = COLW'(x / XW'(COMP_WIDTH));
    line_idx  = LW'(y % YW'(COMP_HEIGHT));
    in_range  = ({1'b0, x} < (XW+1)'(BINS_X * COMP_WIDTH)) &&
                ({1'b0, y} < (YW+1)'(BINS_Y * COMP_HEIGHT));
    take      = armed & de & in_range;
    blk_first = (x_in_blk == XW'(0));
    blk_last  = (x_in_blk == XW'(COMP_WIDTH - 1));
    if (blk_first) begin
      partial = HW'(pix);
    end else begin
      partial = hcnt + HW'(pix);
    end
  end

  // Track vsync and arm on its rising edge. Issue a one-cycle clear to the buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_d <= 1'b0;
      armed   <= 1'b0;
      bin_cls <= 1'b0;
    end else begin
      vsync_d <= vsync;
      bin_cls <= vs_rise;
      if (vs_rise) begin
        armed <= 1'b1;
      end
    end
  end

  // Horizontal run accumulation. It holds across de gaps. It hands the run sum to the column stage on the closing pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt     <= '0;
      s1_valid <= 1'b0;
      s1_part  <= '0;
      s1_col   <= '0;
      s1_line  <= '0;
    end else begin
      s1_valid <= take & blk_last;
      if (take) begin
        hcnt <= partial;
      end
      if (take && blk_last) begin
        s1_part <= partial;
        s1_col  <= col_idx;
        s1_line <= line_idx;
      end
    end
  end

  // Column read side. The first line of a band overwrites the stale column value, so no clearing pass is needed.
  always_comb begin
    acc_rd   = colacc[s1_col];
    s1_first = (s1_line == LW'(0));
    s1_last  = (s1_line == LW'(COMP_HEIGHT - 1));
    emit     = s1_valid & s1_last;
    if (s1_first) begin
      col_sum = CNT_W'(s1_part);
    end else begin
      col_sum = acc_rd + CNT_W'(s1_part);
    end
  end

  // Column accumulator write-back. The storage has no reset because every band starts by overwriting it.
  always_ff @(posedge clk) begin
    if (s1_valid && !s1_last) begin
      colacc[s1_col] <= col_sum;
    end
  end

  // Registered bin output. It pulses for one cycle when the last line of a band closes a block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_valid <= 1'b0;
      bin       <= 1'b0;
      bin_next  <= 1'b0;
    end else begin
      bin_valid <= emit;
      bin       <= emit & (col_sum > CNT_W'(THRESH));
      bin_next  <= emit & (s1_col == COLW'(BINS_X - 1));
    end
  end

endmodule

// File: tb/tb_bin_compress.sv
// Self-checking bench for bin_compress on a reduced, non-divisible frame.
// The bench drives a 68x43 frame, which gives 8x4 bins.
// Pixels beyond x=63 or y=39 must be dropped.
// A scoreboard entry is pushed when a block's closing pixel is driven.
// The entry holds the expected bin value, the row-end flag and the arrival cycle.
// The entry is popped when bin_valid is seen.

module tb_bin_compress;

  localparam int H  = 68;
  localparam int V  = 43;
  localparam int CW = 8;
  localparam int CH = 10;
  localparam int TH = 40;
  localparam int BX = H / CW;
  localparam int BY = V / CH;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);

  logic          clk = 1'b0;
  logic          rstn;
  logic          vsync;
  logic          de;
  logic          pix;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          bin_valid;
  logic          bin;
  logic          bin_cls;
  logic          bin_next;

  bin_compress #(
    .H_ACT(H), .V_ACT(V), .COMP_WIDTH(CW), .COMP_HEIGHT(CH), .THRESH(TH)
  ) dut (
    .clk(clk), .rstn(rstn), .vsync(vsync), .de(de), .pix(pix), .x(x), .y(y),
    .bin_valid(bin_valid), .bin(bin), .bin_cls(bin_cls), .bin_next(bin_next)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit b;
    bit nx;
    int at;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  bit   img [V][H];
  bit   armed_m  = 1'b0;
  int   bins_seen, next_seen, cls_seen, cls_at, cls_exp;
  bit   obs[$];
  bit   ref_obs[$];

  // Monitor: compare every emitted bin against the scoreboard and log it
  always @(negedge clk) begin
    if (bin_cls) begin
      cls_seen++;
      cls_at = cyc;
    end
    if (bin_next && !bin_valid) begin
      checks++;
      failures++;
      $display("FAIL next_without_valid cyc=%0d got bin_next=1 bin_valid=0", cyc);
    end
    if (bin_valid) begin
      bins_seen++;
      if (bin_next) next_seen++;
      obs.push_back(bin);
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bin cyc=%0d got bin=%0b next=%0b, expected none", cyc, bin, bin_next);
      end else begin
        e = sbq.pop_front();
        if (bin !== e.b || bin_next !== e.nx || cyc != e.at) begin
          failures++;
          $display("FAIL bin_compare got bin=%0b next=%0b cyc=%0d, expected bin=%0b next=%0b cyc=%0d",
                   bin, bin_next, cyc, e.b, e.nx, e.at);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic drive(input bit d, input int xi, input int yi, input bit p);
    de  = d;
    x   = XW'(xi);
    y   = YW'(yi);
    pix = p;
    if (armed_m && d && (xi % CW == CW - 1) && (xi < BX * CW) &&
        (yi < BY * CH) && (yi % CH == CH - 1)) begin
      int   cnt;
      int   bx;
      int   by;
      exp_t ne;
      cnt = 0;
      bx  = xi / CW;
      by  = yi / CH;
      for (int r = 0; r < CH; r++)
        for (int c = 0; c < CW; c++)
          cnt += int'(img[by*CH + r][bx*CW + c]);
      ne.b  = (cnt > TH);
      ne.nx = (bx == BX - 1);
      ne.at = cyc + 2;
      sbq.push_back(ne);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic vsync_pulse();
    vsync   = 1'b1;
    cls_exp = cyc + 1;
    idle(3);
    vsync   = 1'b0;
    armed_m = 1'b1;
    idle(4);
  endtask

  task automatic feed_lines(input int y0, input int y1, input bit gaps);
    for (int yi = y0; yi <= y1; yi++) begin
      for (int xi = 0; xi < H; xi++) begin
        if (gaps && (xi % CW != 0) && ($urandom_range(0, 3) == 0))
          idle($urandom_range(1, 5));
        drive(1'b1, xi, yi, img[yi][xi]);
      end
      idle(4);
    end
  endtask

  task automatic run_frame(input bit gaps);
    bins_seen = 0;
    next_seen = 0;
    cls_seen  = 0;
    obs.delete();
    vsync_pulse();
    feed_lines(0, V - 1, gaps);
    idle(6);
  endtask

  task automatic fill_const(input bit v);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = 1'($urandom_range(0, 1));
  endtask

  function automatic int count_ones();
    int n;
    n = 0;
    foreach (obs[i]) n += int'(obs[i]);
    return n;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; vsync = 1'b0; de = 1'b0; pix = 1'b0; x = '0; y = '0;
    armed_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bin_valid, bin, bin_cls, bin_next} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got %b expected 0000", {bin_valid, bin, bin_cls, bin_next});
    end
    rstn = 1'b1;
    idle(2);
    // Not armed yet: a whole band of set pixels must produce nothing
    fill_const(1'b1);
    bins_seen = 0;
    feed_lines(0, CH - 1, 1'b0);
    idle(6);
    checks++;
    if (bins_seen != 0) begin
      failures++;
      $display("FAIL unarmed_bins got %0d expected 0", bins_seen);
    end
  endtask

  task automatic test_all_ones();
    fill_const(1'b1);
    run_frame(1'b0);
    checks++;
    if (bins_seen != BX * BY) begin
      failures++; $display("FAIL ones_bin_count got %0d expected %0d", bins_seen, BX * BY);
    end
    checks++;
    if (next_seen != BY) begin
      failures++; $display("FAIL ones_next_count got %0d expected %0d", next_seen, BY);
    end
    checks++;
    if (count_ones() != BX * BY) begin
      failures++; $display("FAIL ones_value got %0d ones expected %0d", count_ones(), BX * BY);
    end
    checks++;
    if (cls_seen != 1 || cls_at != cls_exp) begin
      failures++;
      $display("FAIL cls_pulse got count=%0d at=%0d expected count=1 at=%0d", cls_seen, cls_at, cls_exp);
    end
  endtask

  task automatic test_threshold();
    fill_rand();
    for (int r = 0; r < CH; r++)
      for (int c = 0; c < 3 * CW; c++)
        img[r][c] = 1'b0;
    for (int k = 0; k < 40; k++) img[k / CW][k % CW] = 1'b1;
    for (int k = 0; k < 41; k++) img[k / CW][CW + k % CW] = 1'b1;
    run_frame(1'b0);
    checks++;
    if (obs.size() != BX * BY) begin
      failures++; $display("FAIL thresh_count got %0d expected %0d", obs.size(), BX * BY);
    end else begin
      checks++;
      if ({obs[0], obs[1], obs[2]} !== 3'b010) begin
        failures++;
        $display("FAIL thresh_bins got %b%b%b expected 010", obs[0], obs[1], obs[2]);
      end
    end
  endtask

  task automatic test_checker();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = 1'((r + c) & 1);
    run_frame(1'b0);
    checks++;
    if (obs.size() != BX * BY || count_ones() != 0) begin
      failures++;
      $display("FAIL checker_all_zero got size=%0d ones=%0d expected size=%0d ones=0",
               obs.size(), count_ones(), BX * BY);
    end
    // Block (3,1) goes to 41, block (4,1) drops to 39
    img[19][25] = 1'b1;
    img[19][32] = 1'b0;
    run_frame(1'b0);
    checks++;
    if (obs.size() != BX * BY) begin
      failures++; $display("FAIL checker_flip_count got %0d expected %0d", obs.size(), BX * BY);
    end else begin
      checks++;
      if (obs[11] !== 1'b1 || obs[12] !== 1'b0 || count_ones() != 1) begin
        failures++;
        $display("FAIL checker_flip got b11=%0b b12=%0b ones=%0d expected 1 0 1",
                 obs[11], obs[12], count_ones());
      end
    end
  endtask

  task automatic test_gaps();
    int diff;
    fill_rand();
    run_frame(1'b0);
    ref_obs = obs;
    run_frame(1'b1);
    diff = 0;
    if (obs.size() != ref_obs.size()) diff = -1;
    else foreach (obs[i]) if (obs[i] !== ref_obs[i]) diff++;
    checks++;
    if (diff != 0 || obs.size() != BX * BY) begin
      failures++;
      $display("FAIL gap_sequence got diff=%0d size=%0d expected diff=0 size=%0d", diff, obs.size(), BX * BY);
    end
  endtask

  task automatic test_reset_mid();
    fill_rand();
    vsync_pulse();
    feed_lines(0, 24, 1'b0);
    rstn    = 1'b0;
    armed_m = 1'b0;
    #1;
    checks++;
    if ({bin_valid, bin, bin_cls, bin_next} !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_outputs got %b expected 0000", {bin_valid, bin, bin_cls, bin_next});
    end
    idle(3);
    rstn = 1'b1;
    bins_seen = 0;
    feed_lines(25, V - 1, 1'b0);
    idle(6);
    checks++;
    if (bins_seen != 0) begin
      failures++; $display("FAIL midreset_silent got %0d bins expected 0", bins_seen);
    end
    fill_rand();
    run_frame(1'b0);
    checks++;
    if (bins_seen != BX * BY || sbq.size() != 0) begin
      failures++;
      $display("FAIL midreset_recover got %0d bins pending=%0d expected %0d pending=0",
               bins_seen, sbq.size(), BX * BY);
    end
  endtask

  task automatic test_back_to_back();
    fill_const(1'b1);
    run_frame(1'b0);
    fill_const(1'b0);
    run_frame(1'b0);
    checks++;
    if (obs.size() != BX * BY || count_ones() != 0) begin
      failures++;
      $display("FAIL frame2_residue got size=%0d ones=%0d expected size=%0d ones=0",
               obs.size(), count_ones(), BX * BY);
    end
    fill_rand();
    run_frame(1'b1);
    checks++;
    if (bins_seen != BX * BY || next_seen != BY) begin
      failures++;
      $display("FAIL frame3_totals got bins=%0d next=%0d expected %0d %0d", bins_seen, next_seen, BX * BY, BY);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_threshold();
    test_checker();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
